// File: rtl/cpu_pkg.sv
// Shared definitions for the data-side memory responder.
// Holds the FSM state encoding, the data word width, and the byte-merge
// helper that the store path uses to apply a byte-enable mask.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Lane n of the result comes from new_w when be[n] is set, else from old_w.
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [3:0]        be
  );
    logic [WORD_W-1:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_array_be.sv
// Single-port synchronous word array with a per-byte write mask.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears only the read register
//   en    - access strobe for this edge
//   we    - 1 = byte-masked write, 0 = read
//   be    - byte-lane write mask (bit n = lane n)
//   addr  - word index
//   wdata - write data
//   rdata - registered read data, held between reads
module mem_array_be
  import cpu_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // The array itself is never cleared; contents are undefined until written.
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= byte_merge(mem[addr], wdata, be);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_resp.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Accepts one load/store in IDLE, waits LATENCY cycles, performs the access
// on the edge that enters ACK, then pulses ack_o for one cycle.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset (aborts any in-flight request)
//   req_i   - request valid
//   we_i    - 1 = store, 0 = load
//   be_i    - store byte enables
//   addr_i  - byte address, word-aligned and wrapped modulo DEPTH*4
//   data_i  - store data
//   busy_o  - request in flight
//   ack_o   - single-cycle completion pulse
//   data_o  - load data, held until the next load completes
//
// state | meaning
// IDLE  | ready, accepts a request on req_i
// WAIT  | counting down the access latency
// ACK   | access done, ack_o high for this cycle
module data_memory_resp
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, access;

  logic              we_q;
  logic [3:0]        be_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;

  // Byte-offset bits and bits above the index are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= we_i;
      be_q    <= be_i;
      idx_q   <= addr_i[AW+1:2];
      wdata_q <= data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset on the access edge must suppress the write, since the array
  // itself has no reset.
  mem_array_be #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (access && !rst_i),
    .we   (we_q),
    .be   (be_q),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(data_o)
  );

  assign busy_o = (state_q != IDLE);
  assign ack_o  = (state_q == ACK);

endmodule

// File: tb/tb_data_memory_resp.sv
module tb_data_memory_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic        rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        busy, ack;
  logic [31:0] rdata;

  // LATENCY=1 instance
  logic        rst1 = 1'b1, req1 = 1'b0, we1 = 1'b0;
  logic [3:0]  be1 = 4'h0;
  logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
  logic        busy1, ack1;
  logic [31:0] rdata1;

  data_memory_resp #(.DEPTH(1024), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .data_i(wdata), .busy_o(busy), .ack_o(ack), .data_o(rdata)
  );

  data_memory_resp #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_i(req1), .we_i(we1), .be_i(be1),
    .addr_i(addr1), .data_i(wdata1), .busy_o(busy1), .ack_o(ack1), .data_o(rdata1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    int          gap;
    string       tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] last0 = 32'h0;
  logic [31:0] last1 = 32'h0;
  int last_ack1 = -100;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitors: every ack must match a queued expectation.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (ack === 1'b1) begin
      if (q0.size() == 0) check("dut_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check({e.tag, "_data"}, rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) check("dut1_unexpected_ack", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check({e.tag, "_data"}, rdata1, e.data);
        if (e.gap != 0) check({e.tag, "_ack_gap"}, cyc - last_ack1, e.gap);
      end
      last_ack1 = cyc;
    end
  end

  task automatic wait_idle0();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("dut_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while (busy1 !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("dut1_idle_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request to the LATENCY=4 instance and wait for completion.
  task automatic issue0(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_load, input string tag);
    wait_idle0();
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    if (w) q0.push_back('{last0, 0, tag});
    else begin
      q0.push_back('{exp_load, 0, tag});
      last0 = exp_load;
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; be = 4'hF; addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD;
    wait_idle0();
  endtask

  // Hold req1 across three transactions; a new one is accepted every 3 cycles.
  task automatic burst1(input logic w, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input string tag);
    logic [31:0] av[3];
    logic [31:0] dv[3];
    av[0] = a0; av[1] = a1; av[2] = a2;
    dv[0] = d0; dv[1] = d1; dv[2] = d2;
    wait_idle1();
    req1 = 1'b1; we1 = w; be1 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      addr1 = av[i]; wdata1 = dv[i];
      if (w) q1.push_back('{last1, (i == 0) ? 0 : 3, tag});
      else begin
        q1.push_back('{dv[i], (i == 0) ? 0 : 3, tag});
        last1 = dv[i];
      end
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_busy_wait"}, {31'd0, busy1}, 32'd1);
      check({tag, "_ack_wait"}, {31'd0, ack1}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ack_pulse"}, {31'd0, ack1}, 32'd1);
      @(posedge clk); #1;
      if (i == 2) req1 = 1'b0;
    end
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_data", rdata, 32'h0);
    check("rst1_busy", {31'd0, busy1}, 32'd0);
    check("rst1_data", rdata1, 32'h0);

    // Store with detailed handshake timing
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    q0.push_back('{last0, 0, "st10"});
    @(posedge clk); #1;
    req = 1'b0; wdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("st10_busy_c%0d", k), {31'd0, busy}, (k <= 4) ? 32'd1 : 32'd0);
      check($sformatf("st10_ack_c%0d", k), {31'd0, ack}, (k == 4) ? 32'd1 : 32'd0);
    end
    issue0(1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEEF, "ld10");

    // Partial store
    issue0(1'b1, 4'hF, 32'h20, 32'h1122_3344, 32'h0, "st20");
    issue0(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 32'h0, "st20_part");
    issue0(1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB_33DD, "ld20_part");

    // Request during WAIT is ignored
    issue0(1'b1, 4'hF, 32'h40, 32'h0F0F_0F0F, 32'h0, "st40");
    wait_idle0();
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h50; wdata = 32'h1234_5678;
    q0.push_back('{last0, 0, "st50"});
    @(posedge clk); #1;
    addr = 32'h40; wdata = 32'hFFFF_FFFF;
    @(posedge clk); @(posedge clk); #1;
    req = 1'b0;
    wait_idle0();
    repeat (3) @(posedge clk);
    #1;
    issue0(1'b0, 4'h0, 32'h40, 32'h0, 32'h0F0F_0F0F, "ld40_unchanged");
    issue0(1'b0, 4'h0, 32'h50, 32'h0, 32'h1234_5678, "ld50");

    // Wrap, zero byte-enable, low address bits ignored
    issue0(1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D, 32'h0, "st1000");
    issue0(1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFE_F00D, "ld0_wrap");
    issue0(1'b1, 4'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, "st0_be0");
    issue0(1'b0, 4'h0, 32'h0, 32'h0, 32'hCAFE_F00D, "ld0_be0");
    issue0(1'b0, 4'h0, 32'h13, 32'h0, 32'hDEAD_BEEF, "ld13_aligned");

    // Reset mid-operation
    issue0(1'b1, 4'hF, 32'h30, 32'h0102_0304, 32'h0, "st30");
    wait_idle0();
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h30; wdata = 32'h55AA_55AA;
    q0.push_back('{last0, 0, "st30_aborted"});
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b1;
    q0.delete();
    last0 = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_data", rdata, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    issue0(1'b0, 4'h0, 32'h30, 32'h0, 32'h0102_0304, "ld30_prior");

    // Back-to-back with LATENCY=1
    burst1(1'b1, 32'h0, 32'h4, 32'h8, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, "b2b_st");
    burst1(1'b0, 32'h0, 32'h4, 32'h8, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, "b2b_ld");

    repeat (5) @(posedge clk);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
